// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state enum, block geometry helpers and word/block types for the refill engine
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DATA,
        WB_RESP,
        RD_REQ,
        RD_DATA,
        COMMIT
    } refill_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BLOCK_SIZE = 32;

    function automatic int words_per_block(input int block_size, input int data_width);
        return (block_size * 8) / data_width;
    endfunction

    function automatic int offset_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int DEF_WORDS = words_per_block(DEF_BLOCK_SIZE, DEF_DATA_WIDTH);

    typedef logic [DEF_DATA_WIDTH-1:0]   word_t;
    typedef logic [DEF_BLOCK_SIZE*8-1:0] block_t;

endpackage

// File: rtl/wb_block_serializer.sv
// rtl/wb_block_serializer.sv - latches a victim block and presents it one registered word at a time
module wb_block_serializer
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [DATA_WIDTH*WORDS-1:0] block_in,
    input  logic                        advance,
    output logic [DATA_WIDTH-1:0]       tdata,
    output logic                        tlast
);

    localparam int IDXW = offset_width(WORDS);

    logic [DATA_WIDTH*WORDS-1:0] block_q, block_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic [DATA_WIDTH-1:0]       tdata_q, tdata_d;
    logic                        tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0]       words [WORDS];

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            words[i] = block_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The beat on the bus is a flop, so the next word is selected one step ahead of the handshake.
    always_comb begin
        block_d = block_q;
        idx_d   = idx_q;
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        if (load) begin
            block_d = block_in;
            idx_d   = '0;
            tdata_d = block_in[DATA_WIDTH-1:0];
            tlast_d = 1'b0;
        end else if (advance) begin
            idx_d   = idx_q + 1'b1;
            tdata_d = words[idx_d];
            tlast_d = (idx_d == IDXW'(WORDS - 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_q <= '0;
            idx_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            block_q <= block_d;
            idx_q   <= idx_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

    assign tdata = tdata_q;
    assign tlast = tlast_q;

endmodule

// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - miss-path writeback/refill engine; CACHE_CRITICAL_WORD_FIRST_EN selects critical-word-first refill
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_WAYS      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [ADDRESS_WIDTH-1:0]             miss_addr,
    input  logic [$clog2(NUM_WAYS)-1:0]          victim_way,
    input  logic                                 victim_valid,
    input  logic                                 victim_dirty,
    input  logic [ADDRESS_WIDTH-1:0]             victim_addr,
    input  logic [BLOCK_SIZE*8-1:0]              victim_block,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic                                 mem_req_write,
    output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    output logic                                 mem_wdata_valid,
    input  logic                                 mem_wdata_ready,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic                                 mem_wdata_last,
    input  logic                                 mem_wresp_valid,
    input  logic                                 mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    input  logic                                 mem_rdata_last,
    output logic                                 mem_rdata_ready,
    output logic                                 fill_we,
    output logic [$clog2(NUM_WAYS)-1:0]          fill_way,
    output logic [offset_width(words_per_block(BLOCK_SIZE, DATA_WIDTH))-1:0] fill_word,
    output logic [DATA_WIDTH-1:0]                fill_data,
    output logic                                 fill_commit,
    output logic [ADDRESS_WIDTH-1:0]             fill_addr
);

    localparam int WORDS = words_per_block(BLOCK_SIZE, DATA_WIDTH);
    localparam int OFFW  = offset_width(WORDS);
    localparam int WAYW  = $clog2(NUM_WAYS);
    localparam logic [ADDRESS_WIDTH-1:0] BLK_MASK = ADDRESS_WIDTH'(BLOCK_SIZE - 1);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    localparam int BYTE_OFF  = $clog2(BLOCK_SIZE);
    localparam int WBYTE_OFF = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ADDRESS_WIDTH'(DATA_WIDTH / 8 - 1);
`endif

    refill_state_t state_q, state_d;

    logic [OFFW-1:0]          beat_q, beat_d;
    logic [OFFW-1:0]          base_q, base_d;
    logic                     drain_q, drain_d;
    logic                     err_q, err_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     mem_req_valid_q, mem_req_valid_d;
    logic                     mem_req_write_q, mem_req_write_d;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic                     mem_wdata_valid_q, mem_wdata_valid_d;
    logic                     mem_rdata_ready_q, mem_rdata_ready_d;
    logic                     fill_we_q, fill_we_d;
    logic [WAYW-1:0]          fill_way_q, fill_way_d;
    logic [OFFW-1:0]          fill_word_q, fill_word_d;
    logic [DATA_WIDTH-1:0]    fill_data_q, fill_data_d;
    logic                     fill_commit_q, fill_commit_d;
    logic [ADDRESS_WIDTH-1:0] fill_addr_q, fill_addr_d;

    logic                     ser_load, ser_adv, ser_last;
    logic [DATA_WIDTH-1:0]    ser_data;
    logic                     final_beat;

    wb_block_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORDS)
    ) u_wb_ser (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ser_load),
        .block_in (victim_block),
        .advance  (ser_adv),
        .tdata    (ser_data),
        .tlast    (ser_last)
    );

    assign final_beat = (beat_q == OFFW'(WORDS - 1));

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        base_d          = base_q;
        drain_d         = drain_q;
        err_d           = err_q;
        rd_addr_d       = rd_addr_q;
        mem_req_write_d = mem_req_write_q;
        mem_req_addr_d  = mem_req_addr_q;
        fill_we_d       = 1'b0;
        fill_way_d      = fill_way_q;
        fill_word_d     = fill_word_q;
        fill_data_d     = fill_data_q;
        fill_addr_d     = fill_addr_q;
        ser_load        = 1'b0;
        ser_adv         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ser_load    = 1'b1;
                    beat_d      = '0;
                    drain_d     = 1'b0;
                    err_d       = 1'b0;
                    fill_way_d  = victim_way;
                    fill_addr_d = miss_addr & ~BLK_MASK;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                    rd_addr_d   = miss_addr & ~WORD_MASK;
                    base_d      = miss_addr[BYTE_OFF-1:WBYTE_OFF];
`else
                    rd_addr_d   = miss_addr & ~BLK_MASK;
                    base_d      = '0;
`endif
                    if (victim_valid && victim_dirty) begin
                        state_d         = WB_REQ;
                        mem_req_write_d = 1'b1;
                        mem_req_addr_d  = victim_addr;
                    end else begin
                        state_d         = RD_REQ;
                        mem_req_write_d = 1'b0;
                        mem_req_addr_d  = rd_addr_d;
                    end
                end
            end
            WB_REQ: begin
                if (mem_req_ready) state_d = WB_DATA;
            end
            WB_DATA: begin
                if (mem_wdata_ready) begin
                    if (ser_last) state_d = WB_RESP;
                    else          ser_adv = 1'b1;
                end
            end
            WB_RESP: begin
                if (mem_wresp_valid) begin
                    state_d         = RD_REQ;
                    mem_req_write_d = 1'b0;
                    mem_req_addr_d  = rd_addr_q;
                end
            end
            RD_REQ: begin
                if (mem_req_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                // One extra cycle after the closing beat lets its fill_we land before commit.
                if (drain_q) begin
                    state_d = COMMIT;
                end else if (mem_rdata_valid && mem_rdata_ready_q) begin
                    fill_we_d   = 1'b1;
                    fill_data_d = mem_rdata;
                    fill_word_d = base_q + beat_q;
                    beat_d      = beat_q + 1'b1;
                    if (mem_rdata_last || final_beat) begin
                        drain_d = 1'b1;
                        err_d   = (mem_rdata_last != final_beat);
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d            = (state_d != IDLE);
        mem_req_valid_d   = (state_d == WB_REQ) || (state_d == RD_REQ);
        mem_wdata_valid_d = (state_d == WB_DATA);
        mem_rdata_ready_d = (state_d == RD_DATA) && !drain_d;
        done_d            = (state_d == COMMIT);
        error_d           = done_d && err_d;
        fill_commit_d     = done_d && !err_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            beat_q            <= '0;
            base_q            <= '0;
            drain_q           <= 1'b0;
            err_q             <= 1'b0;
            rd_addr_q         <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
            mem_req_valid_q   <= 1'b0;
            mem_req_write_q   <= 1'b0;
            mem_req_addr_q    <= '0;
            mem_wdata_valid_q <= 1'b0;
            mem_rdata_ready_q <= 1'b0;
            fill_we_q         <= 1'b0;
            fill_way_q        <= '0;
            fill_word_q       <= '0;
            fill_data_q       <= '0;
            fill_commit_q     <= 1'b0;
            fill_addr_q       <= '0;
        end else begin
            state_q           <= state_d;
            beat_q            <= beat_d;
            base_q            <= base_d;
            drain_q           <= drain_d;
            err_q             <= err_d;
            rd_addr_q         <= rd_addr_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            error_q           <= error_d;
            mem_req_valid_q   <= mem_req_valid_d;
            mem_req_write_q   <= mem_req_write_d;
            mem_req_addr_q    <= mem_req_addr_d;
            mem_wdata_valid_q <= mem_wdata_valid_d;
            mem_rdata_ready_q <= mem_rdata_ready_d;
            fill_we_q         <= fill_we_d;
            fill_way_q        <= fill_way_d;
            fill_word_q       <= fill_word_d;
            fill_data_q       <= fill_data_d;
            fill_commit_q     <= fill_commit_d;
            fill_addr_q       <= fill_addr_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign mem_req_valid   = mem_req_valid_q;
    assign mem_req_write   = mem_req_write_q;
    assign mem_req_addr    = mem_req_addr_q;
    assign mem_wdata_valid = mem_wdata_valid_q;
    assign mem_wdata       = ser_data;
    assign mem_wdata_last  = ser_last;
    assign mem_rdata_ready = mem_rdata_ready_q;
    assign fill_we         = fill_we_q;
    assign fill_way        = fill_way_q;
    assign fill_word       = fill_word_q;
    assign fill_data       = fill_data_q;
    assign fill_commit     = fill_commit_q;
    assign fill_addr       = fill_addr_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// tb/tb_cache_refill_engine.sv - scoreboard bench for cache_refill_engine with a reactive memory model
module tb_cache_refill_engine;
    import cache_pkg::*;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [31:0]  miss_addr;
    logic [1:0]   victim_way;
    logic         victim_valid, victim_dirty;
    logic [31:0]  victim_addr;
    block_t       victim_block;
    logic         busy, done, error;
    logic         mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0]  mem_req_addr;
    logic         mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
    word_t        mem_wdata;
    logic         mem_wresp_valid;
    logic         mem_rdata_valid, mem_rdata_last, mem_rdata_ready;
    word_t        mem_rdata;
    logic         fill_we, fill_commit;
    logic [1:0]   fill_way;
    logic [2:0]   fill_word;
    word_t        fill_data;
    logic [31:0]  fill_addr;

    cache_refill_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .miss_addr(miss_addr),
        .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_addr(victim_addr), .victim_block(victim_block),
        .busy(busy), .done(done), .error(error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
        .mem_wresp_valid(mem_wresp_valid),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .mem_rdata_last(mem_rdata_last), .mem_rdata_ready(mem_rdata_ready),
        .fill_we(fill_we), .fill_way(fill_way), .fill_word(fill_word),
        .fill_data(fill_data), .fill_commit(fill_commit), .fill_addr(fill_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [2:0] word; logic [31:0] data; logic [1:0] way; } fill_exp_t;
    typedef struct packed { logic write; logic [31:0] addr; } req_exp_t;
    typedef struct packed { logic [31:0] data; logic last; } wb_exp_t;
    typedef struct packed { logic err; logic [31:0] addr; logic [1:0] way; } done_exp_t;

    fill_exp_t exp_fill[$];
    req_exp_t  exp_req[$];
    wb_exp_t   exp_wb[$];
    done_exp_t exp_done[$];

    int n_checks = 0;
    int n_errors = 0;
    int req_rel, fill_rel, done_rel;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (fill_we) begin
                if (exp_fill.size() == 0) begin
                    check_eq("unexpected_fill", 1, 0);
                end else begin
                    automatic fill_exp_t f = exp_fill.pop_front();
                    check_eq("fill_word", fill_word, f.word);
                    check_eq("fill_data", fill_data, f.data);
                    check_eq("fill_way", fill_way, f.way);
                end
            end
            if (fill_commit && !done) check_eq("stray_commit", 1, 0);
            if (done) begin
                if (exp_done.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    automatic done_exp_t d = exp_done.pop_front();
                    check_eq("done_error", error, d.err);
                    check_eq("done_commit", fill_commit, !d.err);
                    check_eq("done_fill_addr", fill_addr, d.addr);
                    check_eq("done_busy", busy, 1);
                end
            end
        end
    end

    task automatic run_miss(input logic [31:0] addr, input logic [1:0] way,
                            input logic vvalid, input logic vdirty, input logic [31:0] vaddr,
                            input logic [31:0] dbase, input logic [31:0] rbase,
                            input int last_beat, input int stall, input bit gaps,
                            input bit poke_start, input int abort_at);
        int k = 0, budget = 0, rel, wresp_wait = -1, stall_left = stall;
        bit done_seen = 0, aborted = 0;
        int t0;
        logic [31:0] rd_addr = CWF ? (addr & ~32'h3) : (addr & ~32'h1F);
        logic [2:0]  base = CWF ? addr[4:2] : 3'd0;
        @(negedge clk);
        miss_addr = addr; victim_way = way; victim_valid = vvalid; victim_dirty = vdirty;
        victim_addr = vaddr;
        for (int i = 0; i < 8; i++) victim_block[i*32 +: 32] = dbase + 32'(i);
        start = 1'b1;
        t0 = cyc;
        req_rel = -1; fill_rel = -1; done_rel = -1;
        if (vvalid && vdirty) begin
            exp_req.push_back('{write: 1'b1, addr: vaddr});
            for (int i = 0; i < 8; i++) exp_wb.push_back('{data: dbase + 32'(i), last: (i == 7)});
        end
        exp_req.push_back('{write: 1'b0, addr: rd_addr});
        exp_done.push_back('{err: (last_beat != 7), addr: addr & ~32'h1F, way: way});
        while (!done_seen && !aborted && budget < 400) begin
            @(negedge clk);
            budget++;
            rel = cyc - t0;
            start = poke_start;
            if (poke_start) miss_addr = addr + 32'h100;
            mem_req_ready = 0; mem_wdata_ready = 0; mem_wresp_valid = 0;
            mem_rdata_valid = 0; mem_rdata_last = 0;
            if (done) begin done_seen = 1; done_rel = rel; start = 0; end
            if (fill_we && fill_rel < 0) fill_rel = rel;
            if (mem_req_valid) begin
                if (req_rel < 0) req_rel = rel;
                if (exp_req.size() == 0) begin
                    check_eq("unexpected_req", 1, 0);
                end else begin
                    check_eq("req_addr", mem_req_addr, exp_req[0].addr);
                    check_eq("req_write", mem_req_write, exp_req[0].write);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_req_ready = 1;
                        void'(exp_req.pop_front());
                        stall_left = stall;
                    end
                end
            end
            if (wresp_wait == 0) begin mem_wresp_valid = 1; wresp_wait = -1; end
            else if (wresp_wait > 0) wresp_wait--;
            if (mem_wdata_valid) begin
                mem_wdata_ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (mem_wdata_ready) begin
                    if (exp_wb.size() == 0) begin
                        check_eq("unexpected_wbeat", 1, 0);
                    end else begin
                        automatic wb_exp_t w = exp_wb.pop_front();
                        check_eq("wb_data", mem_wdata, w.data);
                        check_eq("wb_last", mem_wdata_last, w.last);
                        if (w.last) wresp_wait = 1;
                    end
                end
            end
            if (mem_rdata_ready && k <= last_beat && k < 8) begin
                if (abort_at == k) begin
                    aborted = 1;
                end else if (!gaps || $urandom_range(0, 2) != 0) begin
                    mem_rdata_valid = 1;
                    mem_rdata = rbase + 32'(k);
                    mem_rdata_last = (k == last_beat);
                    exp_fill.push_back('{word: base + 3'(k), data: rbase + 32'(k), way: way});
                    k++;
                end
            end
        end
        start = 0;
        if (aborted) begin
            @(posedge clk);
            #2 reset_n = 0;
            #1;
            check_eq("rst_busy", busy, 0);
            check_eq("rst_rready", mem_rdata_ready, 0);
            check_eq("rst_fill_we", fill_we, 0);
            check_eq("rst_fill_data", fill_data, 0);
            check_eq("rst_commit", fill_commit, 0);
            check_eq("rst_done", done, 0);
            exp_fill.delete(); exp_done.delete(); exp_req.delete(); exp_wb.delete();
            repeat (2) @(negedge clk);
            reset_n = 1;
        end else begin
            check_eq("miss_finished", done_seen, 1);
            check_eq("fill_left", exp_fill.size(), 0);
            check_eq("req_left", exp_req.size(), 0);
            check_eq("wb_left", exp_wb.size(), 0);
        end
    endtask

    initial begin
        reset_n = 0; start = 0; miss_addr = 0; victim_way = 0; victim_valid = 0;
        victim_dirty = 0; victim_addr = 0; victim_block = '0;
        mem_req_ready = 0; mem_wdata_ready = 0; mem_wresp_valid = 0;
        mem_rdata_valid = 0; mem_rdata = 0; mem_rdata_last = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_req_valid", mem_req_valid, 0);
        check_eq("reset_wdata_valid", mem_wdata_valid, 0);
        check_eq("reset_fill_we", fill_we, 0);
        check_eq("reset_done", done, 0);
        reset_n = 1;
        @(negedge clk);

        // clean miss, zero-wait memory: cycle-exact latency
        run_miss(32'h0000_1040, 2'd2, 1, 0, 32'h0, 32'h0, 32'hA0, 7, 0, 0, 0, -1);
        check_eq("t_req", req_rel, 1);
        check_eq("t_first_fill", fill_rel, 3);
        check_eq("t_done", done_rel, 11);
        @(negedge clk);
        check_eq("t_idle_after", busy, 0);

        // dirty victim: writeback burst precedes refill
        run_miss(32'h0000_3080, 2'd1, 1, 1, 32'h0000_2000, 32'h10, 32'hB0, 7, 0, 0, 0, -1);

        // offset miss: critical word first when enabled, block order otherwise; dirty but invalid victim skips writeback
        run_miss(32'h0000_1054, 2'd3, 0, 1, 32'h0000_5000, 32'h20, 32'hC0, 7, 0, 0, 0, -1);

        // early last on beat 3
        run_miss(32'h0000_4000, 2'd0, 1, 0, 32'h0, 32'h0, 32'hD0, 3, 0, 0, 0, -1);

        // stalled request, random gaps, start held during busy
        run_miss(32'h0000_6064, 2'd2, 1, 1, 32'h0000_7000, 32'h30, 32'hE0, 7, 4, 1, 1, -1);
        @(negedge clk);
        check_eq("start_busy_ignored", busy, 0);

        // reset in the middle of the refill, then a fresh miss
        run_miss(32'h0000_8000, 2'd1, 1, 0, 32'h0, 32'h0, 32'hF0, 7, 0, 0, 0, 4);
        run_miss(32'h0000_9040, 2'd3, 1, 0, 32'h0, 32'h0, 32'h50, 7, 0, 0, 0, -1);

        repeat (3) @(negedge clk);
        check_eq("final_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
